// File: rtl/sr_cmd_debouncer_pkg.sv
// sr_cmd_debouncer_pkg: shared channel FSM encoding and default parameter values
package sr_cmd_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } chan_state_e;

    localparam int SYNC_STAGES_DEF  = 2;
    localparam int DEBOUNCE_CNT_DEF = 4;
    localparam int CNT_W_DEF        = 3;
    localparam int CLR_PRIORITY_DEF = 1;

endpackage

// File: rtl/sr_cmd_debouncer_debounce_chan.sv
// sr_cmd_debouncer_debounce_chan: synchroniser, debounce counter/FSM and rise pulse for one request line
module sr_cmd_debouncer_debounce_chan
    import sr_cmd_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic lvl,
    output logic acc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               SINGLE   = (DEBOUNCE_CNT == 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    chan_state_e            state_q, state_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // shift the raw input through the synchroniser chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // state register: synchroniser, debounce counter and FSM state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // next state: count consecutive agreeing samples; any disagreement restarts the channel
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_lvl) begin
                    state_d = SINGLE ? ST_HIGH : ST_RISE;
                    cnt_d   = SINGLE ? '0 : CNT_ONE;
                end
            end
            ST_RISE: begin
                if (!sync_lvl) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_lvl) begin
                    state_d = SINGLE ? ST_IDLE : ST_FALL;
                    cnt_d   = SINGLE ? '0 : CNT_ONE;
                end
            end
            ST_FALL: begin
                if (sync_lvl) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // outputs: debounced level from state, accept only on the transition into HIGH from below
    always_comb begin
        lvl = (state_q == ST_HIGH) || (state_q == ST_FALL);
        acc = sync_lvl && (((state_q == ST_RISE) && (cnt_q == CNT_LAST)) || (SINGLE && (state_q == ST_IDLE)));
    end

endmodule

// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: debounced set/clear request front-end producing exclusive one-cycle s/r pulses
module sr_cmd_debouncer
    import sr_cmd_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int CLR_PRIORITY = CLR_PRIORITY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic set_lvl,
    output logic clr_lvl,
    output logic conflict
);

    localparam bit CLR_WINS = (CLR_PRIORITY != 0);

    logic set_acc, clr_acc;
    logic s_q, s_d, r_q, r_d, conflict_q, conflict_d;

    sr_cmd_debouncer_debounce_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_W       (CNT_W)
    ) u_set_chan (
        .clk  (clk),
        .reset(reset),
        .din  (set_in),
        .lvl  (set_lvl),
        .acc  (set_acc)
    );

    sr_cmd_debouncer_debounce_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_W       (CNT_W)
    ) u_clr_chan (
        .clk  (clk),
        .reset(reset),
        .din  (clr_in),
        .lvl  (clr_lvl),
        .acc  (clr_acc)
    );

    // arbitration: same-cycle accepts keep only the priority side, the loser is dropped
    always_comb begin
        conflict_d = set_acc && clr_acc;
        s_d        = set_acc && !(clr_acc && CLR_WINS);
        r_d        = clr_acc && !(set_acc && !CLR_WINS);
    end

    // output registers for the pulses and conflict flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// tb_sr_cmd_debouncer: directed scoreboard bench for both clear-priority and set-priority builds
module tb_sr_cmd_debouncer;

    typedef struct {
        int         cyc;
        logic [2:0] src;
    } exp_t;

    logic clk = 1'b0;
    logic reset, set_in, clr_in;
    logic s1, r1, sl1, cl1, c1;
    logic s0, r0, sl0, cl0, c0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_cmd_debouncer #(.CLR_PRIORITY(1)) dut1 (
        .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
        .s(s1), .r(r1), .set_lvl(sl1), .clr_lvl(cl1), .conflict(c1)
    );

    sr_cmd_debouncer #(.CLR_PRIORITY(0)) dut0 (
        .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
        .s(s0), .r(r0), .set_lvl(sl0), .clr_lvl(cl0), .conflict(c0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [2:0] p1, input logic [2:0] p0);
        q1.push_back('{at, p1});
        q0.push_back('{at, p0});
    endtask

    // every cycle with a pulse seen or expected is compared against the scoreboard head
    always @(negedge clk) begin
        logic [2:0] e1, e0;
        exp_t t;
        e1 = 3'b000;
        e0 = 3'b000;
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            t  = q1.pop_front();
            e1 = t.src;
        end
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            t  = q0.pop_front();
            e0 = t.src;
        end
        if ({s1, r1, c1} != 3'b000 || e1 != 3'b000) chk("pulse_srC_clrprio", {29'd0, s1, r1, c1}, {29'd0, e1});
        if ({s0, r0, c0} != 3'b000 || e0 != 3'b000) chk("pulse_srC_setprio", {29'd0, s0, r0, c0}, {29'd0, e0});
    end

    initial begin
        int c;
        reset  = 1'b0;
        set_in = 1'b1;
        clr_in = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("reset_outs_clrprio", {27'd0, s1, r1, sl1, cl1, c1}, 32'd0);
            chk("reset_outs_setprio", {27'd0, s0, r0, sl0, cl0, c0}, 32'd0);
        end
        set_in = 1'b0;
        clr_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        c = cyc;
        set_in = 1'b1;
        expect_pulse(c + 6, 3'b100, 3'b100);
        repeat (5) @(negedge clk);
        chk("set_lvl_before_accept", {31'd0, sl1}, 32'd0);
        @(negedge clk);
        chk("set_lvl_at_accept", {31'd0, sl1}, 32'd1);
        repeat (4) @(negedge clk);
        set_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("set_lvl_before_release", {31'd0, sl1}, 32'd1);
        @(negedge clk);
        chk("set_lvl_released", {31'd0, sl1}, 32'd0);
        repeat (4) @(negedge clk);
        repeat (5) begin
            set_in = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("glitch_set_lvl", {31'd0, sl1}, 32'd0);
            end
            set_in = 1'b0;
            repeat (2) begin
                @(negedge clk);
                chk("glitch_set_lvl", {31'd0, sl1}, 32'd0);
            end
        end
        repeat (6) @(negedge clk);
        chk("glitch_set_lvl_after", {31'd0, sl1}, 32'd0);
        c = cyc;
        set_in = 1'b1;
        clr_in = 1'b1;
        expect_pulse(c + 6, 3'b011, 3'b101);
        repeat (6) @(negedge clk);
        chk("both_lvls_conflict", {30'd0, sl1, cl1}, 32'd3);
        repeat (4) @(negedge clk);
        set_in = 1'b0;
        clr_in = 1'b0;
        repeat (10) @(negedge clk);
        c = cyc;
        set_in = 1'b1;
        @(negedge clk);
        clr_in = 1'b1;
        expect_pulse(c + 6, 3'b100, 3'b100);
        expect_pulse(c + 7, 3'b010, 3'b010);
        repeat (10) @(negedge clk);
        set_in = 1'b0;
        clr_in = 1'b0;
        repeat (10) @(negedge clk);
        c = cyc;
        set_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_outs_clrprio", {27'd0, s1, r1, sl1, cl1, c1}, 32'd0);
        chk("midreset_outs_setprio", {27'd0, s0, r0, sl0, cl0, c0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        expect_pulse(c + 10, 3'b100, 3'b100);
        repeat (5) @(negedge clk);
        chk("set_lvl_before_reaccept", {31'd0, sl1}, 32'd0);
        @(negedge clk);
        chk("set_lvl_reaccept", {31'd0, sl1}, 32'd1);
        repeat (4) @(negedge clk);
        set_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("scoreboard_drained_clrprio", q1.size(), 32'd0);
        chk("scoreboard_drained_setprio", q0.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
